// File: rtl/cache_refill.sv
`default_nettype none
// ============================================================================
// Module   : cache_refill
// Purpose  : Cache line refill engine. It invalidates the line, fetches 16
//            words with one read outstanding, writes the data and tag arrays,
//            and forwards the missing word to the requester.
// Config   : CRIT_WORD_FIRST_EN - the fetch starts at the missing word and
//            wraps around the line.
// Revision : 1.0 - initial release
// ============================================================================
module cache_refill #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_miss_req,
  input  logic [31:0]         i_miss_addr,
  output logic                o_busy,
  output logic                o_miss_ack,
  output logic                o_mem_rd_valid,
  input  logic                i_mem_rd_ready,
  output logic [31:0]         o_mem_addr,
  input  logic                i_mem_resp_valid,
  input  logic [WORD_W-1:0]   i_mem_resp_data,
  output logic                o_cw_en,
  output logic [INDEX_W-1:0]  o_cw_index,
  output logic [OFFSET_W-1:0] o_cw_offset,
  output logic [WORD_W-1:0]   o_cw_data,
  output logic                o_tw_en,
  output logic [INDEX_W-1:0]  o_tw_index,
  output logic [TAG_W-1:0]    o_tw_tag,
  output logic                o_tw_valid,
  output logic                o_fwd_valid,
  output logic [WORD_W-1:0]   o_fwd_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INVAL = 3'd1,
    S_REQ   = 3'd2,
    S_WAIT  = 3'd3,
    S_TAG   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state, w_next;
  logic [TAG_W-1:0]    r_tag, w_tag;
  logic [INDEX_W-1:0]  r_index, w_index;
  logic [OFFSET_W-1:0] r_miss_off, w_miss_off;
  logic [OFFSET_W-1:0] r_ctr, w_ctr, r_cnt, w_cnt, w_start;
  logic                w_cap;

  logic                r_busy, r_miss_ack, r_mem_rd_valid, r_cw_en, r_tw_en;
  logic                r_tw_valid, r_fwd_valid;
  logic [31:0]         r_mem_addr;
  logic [INDEX_W-1:0]  r_cw_index, r_tw_index;
  logic [OFFSET_W-1:0] r_cw_offset;
  logic [WORD_W-1:0]   r_cw_data, r_fwd_data;
  logic [TAG_W-1:0]    r_tw_tag;

`ifdef CRIT_WORD_FIRST_EN
  assign w_start = i_miss_addr[OFFSET_W-1:0];
`else
  assign w_start = '0;
`endif

  always_comb begin
    w_next     = r_state;
    w_tag      = r_tag;
    w_index    = r_index;
    w_miss_off = r_miss_off;
    w_ctr      = r_ctr;
    w_cnt      = r_cnt;
    w_cap      = 1'b0;
    case (r_state)
      S_IDLE: if (i_miss_req) begin
        w_next     = S_INVAL;
        w_tag      = i_miss_addr[INDEX_W+OFFSET_W +: TAG_W];
        w_index    = i_miss_addr[OFFSET_W +: INDEX_W];
        w_miss_off = i_miss_addr[OFFSET_W-1:0];
        w_ctr      = w_start;
        w_cnt      = '0;
      end
      S_INVAL: w_next = S_REQ;
      S_REQ:   if (i_mem_rd_ready) w_next = S_WAIT;
      S_WAIT: if (i_mem_resp_valid) begin
        // r_cnt counts words already written; all-ones means this is the last
        w_cap  = 1'b1;
        w_ctr  = r_ctr + 1'b1;
        w_cnt  = r_cnt + 1'b1;
        w_next = (r_cnt == '1) ? S_TAG : S_REQ;
      end
      S_TAG:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_tag          <= '0;
      r_index        <= '0;
      r_miss_off     <= '0;
      r_ctr          <= '0;
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_miss_ack     <= 1'b0;
      r_mem_rd_valid <= 1'b0;
      r_mem_addr     <= '0;
      r_cw_en        <= 1'b0;
      r_cw_index     <= '0;
      r_cw_offset    <= '0;
      r_cw_data      <= '0;
      r_tw_en        <= 1'b0;
      r_tw_index     <= '0;
      r_tw_tag       <= '0;
      r_tw_valid     <= 1'b0;
      r_fwd_valid    <= 1'b0;
      r_fwd_data     <= '0;
    end else begin
      r_state        <= w_next;
      r_tag          <= w_tag;
      r_index        <= w_index;
      r_miss_off     <= w_miss_off;
      r_ctr          <= w_ctr;
      r_cnt          <= w_cnt;
      // Outputs are decoded from the next state so they line up with it
      r_busy         <= (w_next != S_IDLE);
      r_miss_ack     <= (w_next == S_DONE);
      r_mem_rd_valid <= (w_next == S_REQ);
      r_mem_addr     <= (w_next == S_REQ) ? 32'({r_tag, r_index, w_ctr}) : '0;
      r_cw_en        <= w_cap;
      r_cw_index     <= w_cap ? r_index : '0;
      r_cw_offset    <= w_cap ? r_ctr : '0;
      r_cw_data      <= w_cap ? i_mem_resp_data : '0;
      r_tw_en        <= (w_next == S_INVAL) || (w_next == S_TAG);
      r_tw_index     <= ((w_next == S_INVAL) || (w_next == S_TAG)) ? w_index : '0;
      r_tw_tag       <= (w_next == S_TAG) ? r_tag : '0;
      r_tw_valid     <= (w_next == S_TAG);
      r_fwd_valid    <= w_cap && (r_ctr == r_miss_off);
      r_fwd_data     <= (w_cap && (r_ctr == r_miss_off)) ? i_mem_resp_data : '0;
    end
  end

  assign o_busy         = r_busy;
  assign o_miss_ack     = r_miss_ack;
  assign o_mem_rd_valid = r_mem_rd_valid;
  assign o_mem_addr     = r_mem_addr;
  assign o_cw_en        = r_cw_en;
  assign o_cw_index     = r_cw_index;
  assign o_cw_offset    = r_cw_offset;
  assign o_cw_data      = r_cw_data;
  assign o_tw_en        = r_tw_en;
  assign o_tw_index     = r_tw_index;
  assign o_tw_tag       = r_tw_tag;
  assign o_tw_valid     = r_tw_valid;
  assign o_fwd_valid    = r_fwd_valid;
  assign o_fwd_data     = r_fwd_data;

endmodule
`default_nettype wire

// File: tb/tb_cache_refill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_refill
// Purpose  : Randomized bench for cache_refill with a line-level reference
//            model and a behavioural memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_refill;

`ifdef CRIT_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss_req = 1'b0;
  logic [31:0] i_miss_addr = '0;
  logic        i_mem_rd_ready = 1'b0;
  logic        i_mem_resp_valid = 1'b0;
  logic [31:0] i_mem_resp_data = '0;
  logic        o_busy, o_miss_ack, o_mem_rd_valid, o_cw_en, o_tw_en, o_tw_valid, o_fwd_valid;
  logic [31:0] o_mem_addr, o_cw_data, o_fwd_data;
  logic [7:0]  o_cw_index, o_tw_index;
  logic [3:0]  o_cw_offset;
  logic [19:0] o_tw_tag;

  always #5 clk = ~clk;

  cache_refill dut (
    .clk(clk), .rst(rst),
    .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
    .o_busy(o_busy), .o_miss_ack(o_miss_ack),
    .o_mem_rd_valid(o_mem_rd_valid), .i_mem_rd_ready(i_mem_rd_ready), .o_mem_addr(o_mem_addr),
    .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_data(i_mem_resp_data),
    .o_cw_en(o_cw_en), .o_cw_index(o_cw_index), .o_cw_offset(o_cw_offset), .o_cw_data(o_cw_data),
    .o_tw_en(o_tw_en), .o_tw_index(o_tw_index), .o_tw_tag(o_tw_tag), .o_tw_valid(o_tw_valid),
    .o_fwd_valid(o_fwd_valid), .o_fwd_data(o_fwd_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Line-level model state
  bit          fill_act, pending, inval_due, wr_due, tag_due, ack_due, rst_due, prev_stall;
  logic [31:0] fill_addr, rd_addr, prev_addr, wr_addr, wr_data, salt;
  int          reads, writes, dly, acc_cyc, cyc, fills, acks;
  // Memory behaviour knobs
  bit          rdy_rand, spur_en;
  int          dly_max = 1, stall_word = -1, stall_left = 0, exp_lat = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // n-th word address fetched for a miss on 'base'
  function automatic logic [31:0] exp_rd_addr(input logic [31:0] base, input int n);
    logic [3:0] w;
    w = (CRIT ? base[3:0] : 4'd0) + 4'(n);
    return {base[31:4], w};
  endfunction

  always @(negedge clk) begin
    bit fa0, exp_rd, exp_fwd, nx_wr, nx_tag;
    cyc++;
    fa0    = fill_act;
    exp_rd = fill_act && !pending && (reads < 16) && !inval_due;
    chk("busy", o_busy, fill_act);
    chk("cw_en", o_cw_en, wr_due);
    chk("tw_en", o_tw_en, inval_due | tag_due);
    chk("miss_ack", o_miss_ack, ack_due);
    chk("mem_rd_valid", o_mem_rd_valid, exp_rd);
    exp_fwd = wr_due && (wr_addr[3:0] == fill_addr[3:0]);
    chk("fwd_valid", o_fwd_valid, exp_fwd);
    if (wr_due) begin
      chk("cw_index", o_cw_index, wr_addr[11:4]);
      chk("cw_offset", o_cw_offset, wr_addr[3:0]);
      chk("cw_data", o_cw_data, wr_data);
      if (exp_fwd) chk("fwd_data", o_fwd_data, wr_data);
      writes++;
    end
    if (inval_due) begin
      chk("inval_tw_valid", o_tw_valid, 0);
      chk("inval_tw_index", o_tw_index, fill_addr[11:4]);
    end
    if (tag_due) begin
      chk("tag_tw_valid", o_tw_valid, 1);
      chk("tag_tw_index", o_tw_index, fill_addr[11:4]);
      chk("tag_tw_tag", o_tw_tag, fill_addr[31:12]);
    end
    if (o_miss_ack) acks++;
    if (ack_due && exp_lat != 0) chk("ack_latency", cyc - acc_cyc, exp_lat);
    if (rst_due) begin
      chk("rst_mem_addr", o_mem_addr, 0);
      chk("rst_cw_data", o_cw_data, 0);
      chk("rst_tw_tag", o_tw_tag, 0);
      chk("rst_tw_valid", o_tw_valid, 0);
    end
    if (exp_rd) begin
      if (prev_stall) chk("addr_stable", o_mem_addr, prev_addr);
      chk("mem_addr", o_mem_addr, exp_rd_addr(fill_addr, reads));
    end

    if (ack_due) fill_act = 1'b0;
    ack_due   = tag_due;
    inval_due = 1'b0;
    nx_wr     = 1'b0;
    nx_tag    = 1'b0;
    rst_due   = 1'b0;
    if (rst) begin
      fill_act = 0; pending = 0; ack_due = 0; prev_stall = 0; rst_due = 1;
      i_mem_resp_valid = 1'b0;
      i_mem_rd_ready   = 1'b0;
    end else begin
      i_mem_resp_valid = 1'b0;
      i_mem_resp_data  = $urandom;
      if (pending) begin
        dly--;
        if (dly == 0) begin
          pending = 0;
          i_mem_resp_valid = 1'b1;
          i_mem_resp_data  = mem_word(rd_addr);
          nx_wr   = 1'b1;
          wr_addr = rd_addr;
          wr_data = i_mem_resp_data;
          if (reads == 16) nx_tag = 1'b1;
        end
      end
      i_mem_rd_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (exp_rd && reads == stall_word && stall_left > 0) begin
        i_mem_rd_ready = 1'b0;
        stall_left--;
      end
      prev_stall = exp_rd && !i_mem_rd_ready;
      prev_addr  = o_mem_addr;
      if (exp_rd && i_mem_rd_ready) begin
        pending = 1;
        dly     = $urandom_range(1, dly_max);
        rd_addr = exp_rd_addr(fill_addr, reads);
        reads++;
      end
      if (!pending && !nx_wr && spur_en && $urandom_range(0, 3) == 0)
        i_mem_resp_valid = 1'b1;
      if (!fa0 && i_miss_req) begin
        fill_act  = 1; fill_addr = i_miss_addr;
        reads = 0; writes = 0; inval_due = 1; acc_cyc = cyc; fills++;
      end
    end
    wr_due  = nx_wr;
    tag_due = nx_tag;
  end

  task automatic start_miss(input logic [31:0] addr);
    @(posedge clk); #2;
    i_miss_req  = 1'b1;
    i_miss_addr = addr;
    @(posedge clk); #2;
    i_miss_req  = 1'b0;
    i_miss_addr = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (fill_act && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    @(posedge clk); #2;
    chk("idle_timeout", o_busy, 0);
  endtask

  task automatic set_zero_wait(input int lat);
    rdy_rand = 0; dly_max = 1; spur_en = 0; exp_lat = lat;
  endtask

  initial begin
    logic [31:0] edges [3];
    int n, f0;
    salt = $urandom;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset_busy", o_busy, 0);
    chk("reset_rd_valid", o_mem_rd_valid, 0);
    chk("reset_tw_en", o_tw_en, 0);

    // Reference fill plus first/last word offsets, zero-wait memory
    set_zero_wait(35);
    edges[0] = 32'h0001_2345; edges[1] = 32'hABCD_E670; edges[2] = 32'h7654_321F;
    for (int i = 0; i < 3; i++) begin
      start_miss(edges[i]);
      wait_idle(200);
    end

    // Three-cycle ready stall on the third word
    stall_word = 2; stall_left = 3; exp_lat = 38;
    start_miss($urandom);
    wait_idle(200);
    stall_word = -1;

    // Random ready/response timing with spurious responses
    rdy_rand = 1; dly_max = 3; spur_en = 1; exp_lat = 0;
    for (int i = 0; i < 6; i++) begin
      salt = $urandom;
      start_miss($urandom);
      wait_idle(400);
    end

    // Reset in the middle of a fill, then a clean fill
    set_zero_wait(35);
    start_miss($urandom);
    n = 0;
    while (writes < 7 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_busy", o_busy, 0);
    start_miss($urandom);
    wait_idle(200);

    // miss_req held high with spurious responses and random timing
    rdy_rand = 1; dly_max = 2; spur_en = 1; exp_lat = 0;
    f0 = fills; acks = 0;
    @(posedge clk); #2;
    i_miss_req = 1'b1;
    n = 0;
    while (fills < f0 + 3 && n < 600) begin
      i_miss_addr = $urandom;
      @(posedge clk); #2;
      n++;
    end
    i_miss_req = 1'b0;
    wait_idle(300);
    chk("held_acks", acks, fills - f0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
